mod_voice_ctrl: RTL and testbench

Single-voice controller that sequences the additive sine synthesiser. It accepts note-on/note-off commands over a valid/ready handshake and generates the sample-rate tick. It drives the synth's time base, period and four harmonic attenuations. It also shapes an attack/sustain/release envelope onto the output attenuation, with every parameter change aligned to a sample boundary.

---
 rtl/mod_synth_pkg.sv | 24 ++
 rtl/mod_tick_div.sv | 33 +++
 rtl/mod_voice_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mod_voice_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mod_synth_pkg.sv
// Shared types and constants for the voice controller and its helpers.
package mod_synth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ATTACK,
        SUSTAIN,
        RELEASE
    } voice_state_e;

    localparam int unsigned MIN_PERIOD = 8;
    localparam logic signed [15:0] LEVEL_MAX = 16'sh7FFF;

    // Sustain level clamped into the non-negative envelope range.
    function automatic logic [15:0] clamp_level(input logic signed [15:0] lvl);
        if (lvl < 16'sd0) begin
            return 16'd0;
        end else if (lvl > LEVEL_MAX) begin
            return LEVEL_MAX;
        end
        return lvl;
    endfunction

endpackage

// File: rtl/mod_tick_div.sv
// Free-running sample-rate divider: one-cycle tick when the count sits at SAMPLE_DIV-1.
module mod_tick_div #(
    parameter int unsigned SAMPLE_DIV = 1024
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int unsigned CW = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    // Tick is registered from the next count so it lines up with count==LAST.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == LAST);
        end
    end

    assign o_tick = tick_q;

endmodule

// File: rtl/mod_voice_ctrl.sv
// Single-voice controller: note command handshake, sample tick, synth parameters and
// attack/sustain/release envelope, all applied on sample boundaries.
module mod_voice_ctrl
    import mod_synth_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV   = 1024,
    parameter int unsigned ATTACK_STEP  = 64,
    parameter int unsigned RELEASE_STEP = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_note_valid,
    output logic               o_note_ready,
    input  logic               i_note_on,
    input  logic        [31:0] i_note_period,
    input  logic signed [15:0] i_note_atten1,
    input  logic signed [15:0] i_note_atten2,
    input  logic signed [15:0] i_note_atten3,
    input  logic signed [15:0] i_note_atten4,
    input  logic signed [15:0] i_note_level,
    output logic               o_sample_tick,
    output logic        [63:0] o_time,
    output logic        [31:0] o_period,
    output logic signed [15:0] o_atten1,
    output logic signed [15:0] o_atten2,
    output logic signed [15:0] o_atten3,
    output logic signed [15:0] o_atten4,
    output logic signed [15:0] o_atten_out,
    output logic               o_err
);

    logic tick;

    mod_tick_div #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick_div (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_tick  (tick)
    );

    voice_state_e state_q;

    logic               ready_q;
    logic               pend_q;
    logic               pend_on_q;
    logic        [31:0] pend_period_q;
    logic signed [15:0] pend_a1_q, pend_a2_q, pend_a3_q, pend_a4_q;
    logic signed [15:0] pend_level_q;

    logic        [63:0] time_q;
    logic        [31:0] period_q;
    logic signed [15:0] a1_q, a2_q, a3_q, a4_q;
    logic        [15:0] level_q;
    logic        [15:0] target_q;
    logic               err_q;

    // 17-bit signed envelope math so neither step can wrap.
    logic signed [16:0] lvl17, tgt17, up17, dn17, att_next, rel_next;

    always_comb begin
        lvl17 = $signed({1'b0, level_q});
        tgt17 = $signed({1'b0, target_q});
        up17  = lvl17 + $signed(17'(ATTACK_STEP));
        dn17  = lvl17 - $signed(17'(RELEASE_STEP));
        if (lvl17 < tgt17) begin
            att_next = (up17 > tgt17) ? tgt17 : up17;
        end else if (lvl17 > tgt17) begin
            att_next = (dn17 < tgt17) ? tgt17 : dn17;
        end else begin
            att_next = tgt17;
        end
        rel_next = (dn17 < 17'sd0) ? 17'sd0 : dn17;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            ready_q       <= 1'b1;
            pend_q        <= 1'b0;
            pend_on_q     <= 1'b0;
            pend_period_q <= '0;
            pend_a1_q     <= '0;
            pend_a2_q     <= '0;
            pend_a3_q     <= '0;
            pend_a4_q     <= '0;
            pend_level_q  <= '0;
            time_q        <= '0;
            period_q      <= '0;
            a1_q          <= '0;
            a2_q          <= '0;
            a3_q          <= '0;
            a4_q          <= '0;
            level_q       <= '0;
            target_q      <= '0;
            err_q         <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (i_note_valid && ready_q) begin
                pend_q        <= 1'b1;
                ready_q       <= 1'b0;
                pend_on_q     <= i_note_on;
                pend_period_q <= i_note_period;
                pend_a1_q     <= i_note_atten1;
                pend_a2_q     <= i_note_atten2;
                pend_a3_q     <= i_note_atten3;
                pend_a4_q     <= i_note_atten4;
                pend_level_q  <= i_note_level;
            end
            if (tick) begin
                if (pend_q) begin
                    // Consuming tick: apply the command only, no envelope step.
                    pend_q  <= 1'b0;
                    ready_q <= 1'b1;
                    if (pend_on_q) begin
                        if (pend_period_q < MIN_PERIOD) begin
                            err_q <= 1'b1;
                        end else begin
                            period_q <= pend_period_q;
                            a1_q     <= pend_a1_q;
                            a2_q     <= pend_a2_q;
                            a3_q     <= pend_a3_q;
                            a4_q     <= pend_a4_q;
                            target_q <= clamp_level(pend_level_q);
                            time_q   <= '0;
                            state_q  <= ATTACK;
                        end
                    end else if (state_q == ATTACK || state_q == SUSTAIN) begin
                        state_q <= RELEASE;
                    end
                end else begin
                    unique case (state_q)
                        IDLE: begin
                        end
                        ATTACK: begin
                            level_q <= att_next[15:0];
                            time_q  <= time_q + 64'd1;
                            if (att_next == tgt17) begin
                                state_q <= SUSTAIN;
                            end
                        end
                        SUSTAIN: begin
                            time_q <= time_q + 64'd1;
                        end
                        RELEASE: begin
                            level_q <= rel_next[15:0];
                            time_q  <= time_q + 64'd1;
                            if (rel_next == 17'sd0) begin
                                state_q <= IDLE;
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign o_note_ready  = ready_q;
    assign o_sample_tick = tick;
    assign o_time        = time_q;
    assign o_period      = period_q;
    assign o_atten1      = a1_q;
    assign o_atten2      = a2_q;
    assign o_atten3      = a3_q;
    assign o_atten4      = a4_q;
    assign o_atten_out   = $signed(level_q);
    assign o_err         = err_q;

endmodule

// File: tb/tb_mod_voice_ctrl.sv
// Directed bench for mod_voice_ctrl with SAMPLE_DIV=4 and hand-computed expectations.
module tb_mod_voice_ctrl;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               note_valid = 1'b0;
    logic               note_ready;
    logic               note_on = 1'b0;
    logic        [31:0] note_period = '0;
    logic signed [15:0] a1 = '0, a2 = '0, a3 = '0, a4 = '0, lvl = '0;
    logic               sample_tick;
    logic        [63:0] tm;
    logic        [31:0] period;
    logic signed [15:0] o1, o2, o3, o4, atten_out;
    logic               err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mod_voice_ctrl #(
        .SAMPLE_DIV   (4),
        .ATTACK_STEP  (64),
        .RELEASE_STEP (32)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_note_valid  (note_valid),
        .o_note_ready  (note_ready),
        .i_note_on     (note_on),
        .i_note_period (note_period),
        .i_note_atten1 (a1),
        .i_note_atten2 (a2),
        .i_note_atten3 (a3),
        .i_note_atten4 (a4),
        .i_note_level  (lvl),
        .o_sample_tick (sample_tick),
        .o_time        (tm),
        .o_period      (period),
        .o_atten1      (o1),
        .o_atten2      (o2),
        .o_atten3      (o3),
        .o_atten4      (o4),
        .o_atten_out   (atten_out),
        .o_err         (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // Advance to the sample right after the next tick, when tick-cycle updates are visible.
    task automatic next_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_tick && n < 16);
        if (!sample_tick) check("tick_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic on, input logic [31:0] per, input logic signed [15:0] lv);
        note_valid  = 1'b1;
        note_on     = on;
        note_period = per;
        lvl         = lv;
        @(posedge clk);
        #1;
        note_valid = 1'b0;
    endtask

    task automatic check_env(input string tag, input logic [63:0] exp_lvl, input logic [63:0] exp_t);
        check({tag, "_lvl"}, atten_out, exp_lvl);
        check({tag, "_time"}, tm, exp_t);
    endtask

    initial begin
        int ticks;
        logic signed [15:0] rel_seq [7];
        logic signed [15:0] rtg_seq [5];
        rel_seq = '{16'sd168, 16'sd136, 16'sd104, 16'sd72, 16'sd40, 16'sd8, 16'sd0};
        rtg_seq = '{16'sd168, 16'sd136, 16'sd104, 16'sd72, 16'sd50};
        a1 = 16'sd1; a2 = 16'sd2; a3 = -16'sd3; a4 = 16'sd4;

        // Reset and idle
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", note_ready, 64'd1);
        check("rst_lvl", atten_out, 64'd0);
        check("rst_time", tm, 64'd0);
        rst_n = 1'b1;
        ticks = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (sample_tick) ticks++;
            if (i % 4 == 3) check("idle_tick", sample_tick, 64'd1);
            check("idle_lvl", atten_out, 64'd0);
            check("idle_err", err, 64'd0);
        end
        check("idle_tick_count", ticks, 64'd3);
        check("idle_period", period, 64'd0);
        check("idle_ready", note_ready, 64'd1);

        // Note-on, attack to sustain
        send_cmd(1'b1, 32'd100, 16'sd200);
        @(negedge clk);
        check("on_ready_low", note_ready, 64'd0);
        check("on_period_early", period, 64'd0);
        next_tick();
        check("on_ready_back", note_ready, 64'd1);
        check("on_period", period, 64'd100);
        check("on_a1", o1, 64'd1);
        check("on_a3", o3, -64'sd3);
        check("on_a4", o4, 64'd4);
        check_env("on_apply", 64'd0, 64'd0);
        next_tick(); check_env("att1", 64'd64, 64'd1);
        next_tick(); check_env("att2", 64'd128, 64'd2);
        next_tick(); check_env("att3", 64'd192, 64'd3);
        next_tick(); check_env("att4", 64'd200, 64'd4);
        next_tick(); check_env("sus", 64'd200, 64'd5);

        // Note-off, release to idle
        send_cmd(1'b0, 32'd0, 16'sd0);
        next_tick(); check_env("off_apply", 64'd200, 64'd5);
        for (int i = 0; i < 7; i++) begin
            next_tick();
            check_env("rel", rel_seq[i], 64'(6 + i));
        end
        next_tick(); check_env("idle_frozen", 64'd0, 64'd12);

        // Rejected short period
        send_cmd(1'b1, 32'd5, 16'sd1000);
        next_tick();
        check("rej_err", err, 64'd1);
        check("rej_period", period, 64'd100);
        check_env("rej", 64'd0, 64'd12);
        @(negedge clk);
        check("rej_err_pulse", err, 64'd0);
        next_tick();
        check_env("rej_after", 64'd0, 64'd12);

        // Attack to 200, then retrigger down to 50
        send_cmd(1'b1, 32'd100, 16'sd200);
        for (int i = 0; i < 5; i++) next_tick();
        check_env("pre_rtg", 64'd200, 64'd4);
        send_cmd(1'b1, 32'd40, 16'sd50);
        next_tick();
        check("rtg_period", period, 64'd40);
        check_env("rtg_apply", 64'd200, 64'd0);
        for (int i = 0; i < 5; i++) begin
            next_tick();
            check_env("rtg", rtg_seq[i], 64'(1 + i));
        end
        next_tick(); check_env("rtg_sus", 64'd50, 64'd6);

        // Command on a tick cycle waits for the following tick
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!sample_tick && n < 16);
            if (!sample_tick) check("tick_timeout", 64'd0, 64'd1);
        end
        send_cmd(1'b0, 32'd0, 16'sd0);
        @(negedge clk);
        check("tc_ready", note_ready, 64'd0);
        check_env("tc_same", 64'd50, 64'd7);
        next_tick();
        check("tc_ready_back", note_ready, 64'd1);
        check_env("tc_apply", 64'd50, 64'd7);
        next_tick(); check_env("tc_rel", 64'd18, 64'd8);

        // Async reset mid-release with a command pending
        send_cmd(1'b1, 32'd100, 16'sd200);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_ready", note_ready, 64'd1);
        check("ar_lvl", atten_out, 64'd0);
        check("ar_time", tm, 64'd0);
        check("ar_period", period, 64'd0);
        check("ar_a1", o1, 64'd0);
        check("ar_tick", sample_tick, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_tick();
        check("ar_lost_period", period, 64'd0);
        check_env("ar_idle", 64'd0, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
